// File: rtl/oled_shape_sequencer.sv
// Button-driven display-state sequencer for the OLED shape renderer: debounces up/down,
// stages a pending state and commits it on frame_start. Optional AUTO_CYCLE_EN adds auto-advance.
module oled_shape_sequencer #(
  parameter int unsigned DEBOUNCE_MS    = 200,
  parameter int unsigned AUTO_PERIOD_MS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1k,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        frame_start,
`ifdef AUTO_CYCLE_EN
  input  logic        auto_en,
`endif
  output logic [2:0]  state,
  output logic [1:0]  shape_sel,
  output logic [15:0] shape_color,
  output logic [15:0] ring_color,
  output logic        update_pending
);

  localparam int unsigned     DbW    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE_MS - 1);

  localparam logic [1:0]  SelNone   = 2'd0;
  localparam logic [1:0]  SelCircle = 2'd1;
  localparam logic [1:0]  SelSquare = 2'd2;
  localparam logic [15:0] ColBlack  = 16'h0000;
  localparam logic [15:0] ColGreen  = 16'h07E0;
  localparam logic [15:0] ColOrange = 16'hFC00;
  localparam logic [15:0] ColRed    = 16'hF800;
  localparam logic [15:0] ColWhite  = 16'hFFFF;

  if (DEBOUNCE_MS < 2 || AUTO_PERIOD_MS < 2) begin : g_param_check
    $error("DEBOUNCE_MS and AUTO_PERIOD_MS must both be at least 2");
  end

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     acc_q, acc_d;
  logic [DbW-1:0] cnt_q [2];
  logic [DbW-1:0] cnt_d [2];
  logic [1:0]     press;

  logic [2:0]  p_q, p_d;
  logic [2:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] shape_col_q, shape_col_d;
  logic [15:0] ring_col_q, ring_col_d;
  logic        pending_q, pending_d;

  always_comb begin
    acc_d = acc_q;
    press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_1k) begin
        if (sync2_q[i] == acc_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DbLast) begin
          acc_d[i] = sync2_q[i];
          cnt_d[i] = '0;
          press[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam int unsigned       IdleW    = $clog2(AUTO_PERIOD_MS + 1);
  localparam logic [IdleW-1:0]  IdleLast = IdleW'(AUTO_PERIOD_MS - 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             auto_step;

  // Any manual press (even a cancelling up+down pair) restarts the idle period.
  always_comb begin
    idle_d    = idle_q;
    auto_step = 1'b0;
    if (press != 2'b00 || !auto_en) begin
      idle_d = '0;
    end else if (tick_1k) begin
      if (idle_q == IdleLast) begin
        idle_d    = '0;
        auto_step = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  always_comb begin
    p_d = p_q;
    if (press[0] && !press[1]) begin
      p_d = p_q + 3'd1;
    end else if (press[1] && !press[0]) begin
      p_d = p_q - 3'd1;
`ifdef AUTO_CYCLE_EN
    end else if (auto_step) begin
      p_d = p_q + 3'd1;
`endif
    end
  end

  // Commit samples the pre-press pending value, so a coincident press waits a frame.
  always_comb begin
    state_d     = frame_start ? p_q : state_q;
    pending_d   = (p_d != state_d);
    sel_d       = SelNone;
    shape_col_d = ColBlack;
    ring_col_d  = ColOrange;
    unique case (state_d)
      3'd1: begin sel_d = SelCircle; shape_col_d = ColGreen;  end
      3'd2: begin sel_d = SelCircle; shape_col_d = ColOrange; end
      3'd3: begin sel_d = SelCircle; shape_col_d = ColRed;    end
      3'd4: begin sel_d = SelSquare; shape_col_d = ColGreen;  ring_col_d = ColWhite; end
      3'd5: begin sel_d = SelSquare; shape_col_d = ColOrange; ring_col_d = ColWhite; end
      3'd6: begin sel_d = SelSquare; shape_col_d = ColRed;    ring_col_d = ColWhite; end
      default: begin
        sel_d       = SelNone;
        shape_col_d = ColBlack;
        ring_col_d  = ColOrange;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      acc_q       <= 2'b00;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      p_q         <= 3'd0;
      state_q     <= 3'd0;
      sel_q       <= SelNone;
      shape_col_q <= ColBlack;
      ring_col_q  <= ColOrange;
      pending_q   <= 1'b0;
    end else begin
      sync1_q     <= {btn_down, btn_up};
      sync2_q     <= sync1_q;
      acc_q       <= acc_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      p_q         <= p_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      shape_col_q <= shape_col_d;
      ring_col_q  <= ring_col_d;
      pending_q   <= pending_d;
    end
  end

  assign state          = state_q;
  assign shape_sel      = sel_q;
  assign shape_color    = shape_col_q;
  assign ring_color     = ring_col_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_oled_shape_sequencer.sv
// Directed bench for oled_shape_sequencer: debounce, staged commit, wrap, reset and decode table.
// Exercises auto-advance too when built with AUTO_CYCLE_EN.
module tb_oled_shape_sequencer;

  localparam int unsigned Db = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1k = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        frame_start = 1'b0;
`ifdef AUTO_CYCLE_EN
  logic        auto_en = 1'b0;
`endif
  logic [2:0]  state;
  logic [1:0]  shape_sel;
  logic [15:0] shape_color;
  logic [15:0] ring_color;
  logic        update_pending;

  int n_checks = 0;
  int n_fail   = 0;

  oled_shape_sequencer #(
    .DEBOUNCE_MS   (Db),
    .AUTO_PERIOD_MS(10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1k       (tick_1k),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .frame_start   (frame_start),
`ifdef AUTO_CYCLE_EN
    .auto_en       (auto_en),
`endif
    .state         (state),
    .shape_sel     (shape_sel),
    .shape_color   (shape_color),
    .ring_color    (ring_color),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_sel(input int s);
    case (s)
      1, 2, 3: return 2'd1;
      4, 5, 6: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [15:0] exp_col(input int s);
    case (s)
      1, 4:    return 16'h07E0;
      2, 5:    return 16'hFC00;
      3, 6:    return 16'hF800;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_ring(input int s);
    return (s >= 4 && s <= 6) ? 16'hFFFF : 16'hFC00;
  endfunction

  task automatic check_state(input string tag, input int s);
    check({tag, ".state"},   {29'd0, state},       s);
    check({tag, ".sel"},     {30'd0, shape_sel},   {30'd0, exp_sel(s)});
    check({tag, ".color"},   {16'd0, shape_color}, {16'd0, exp_col(s)});
    check({tag, ".ring"},    {16'd0, ring_color},  {16'd0, exp_ring(s)});
    check({tag, ".pending"}, {31'd0, update_pending}, 32'd0);
  endtask

  // One clock with the given strobes; returns 1 ns after the edge.
  task automatic cyc(input logic tk, input logic fs);
    tick_1k     = tk;
    frame_start = fs;
    @(posedge clk);
    #1;
    tick_1k     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
  endtask

  // Two idle clocks let the new level through the synchroniser before ticks count.
  task automatic set_btn(input logic u, input logic d);
    btn_up   = u;
    btn_down = d;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic press(input logic u, input logic d);
    set_btn(u, d);
    ticks(Db);
    set_btn(1'b0, 1'b0);
    ticks(Db);
  endtask

  task automatic frame();
    cyc(1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_state("reset_held", 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ticks(2);
      frame();
    end
    check_state("idle_frames", 0);

    // Bouncing: 50-tick segments never reach acceptance.
    for (int i = 0; i < 8; i++) begin
      set_btn((i % 2) == 0, 1'b0);
      ticks(50);
    end
    ticks(250);
    check("bounce.pending", {31'd0, update_pending}, 32'd0);
    frame();
    check_state("bounce", 0);

    // Held press: acceptance on the 200th tick, no repeat while held.
    set_btn(1'b1, 1'b0);
    ticks(Db - 1);
    check("up199.pending", {31'd0, update_pending}, 32'd0);
    ticks(1);
    check("up200.pending", {31'd0, update_pending}, 32'd1);
    check("up200.state_held", {29'd0, state}, 32'd0);
    ticks(50);
    frame();
    check_state("up_commit", 1);
    set_btn(1'b0, 1'b0);
    ticks(Db);
    frame();
    check_state("up_release", 1);

    // Async reset in the middle of a down debounce.
    set_btn(1'b0, 1'b1);
    ticks(100);
    #2 rst_n = 1'b0;
    #1;
    check_state("mid_reset", 0);
    btn_down = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    ticks(Db + 10);
    frame();
    check_state("post_reset", 0);

    press(1'b0, 1'b1);
    check("down.pending", {31'd0, update_pending}, 32'd1);
    frame();
    check_state("down_wrap", 7);

    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check("up5.state_held", {29'd0, state}, 32'd7);
    frame();
    check_state("up5_accum", 4);

    // Acceptance coinciding with frame_start commits the old pending value.
    set_btn(1'b1, 1'b0);
    ticks(Db - 1);
    cyc(1'b1, 1'b1);
    check("coinc.state", {29'd0, state}, 32'd4);
    check("coinc.pending", {31'd0, update_pending}, 32'd1);
    frame();
    check_state("coinc_next", 5);
    set_btn(1'b0, 1'b0);
    ticks(Db);

    press(1'b1, 1'b1);
    check("simul.pending", {31'd0, update_pending}, 32'd0);
    frame();
    check_state("simul", 5);

    press(1'b1, 1'b0);
    frame();
    check_state("dec6", 6);
    press(1'b1, 1'b0);
    frame();
    check_state("dec7", 7);
    press(1'b1, 1'b0);
    frame();
    check_state("up_wrap0", 0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    frame();
    check_state("dec2", 2);
    press(1'b1, 1'b0);
    frame();
    check_state("dec3", 3);

`ifdef AUTO_CYCLE_EN
    auto_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ticks(9);
      check("auto9.pending", {31'd0, update_pending}, 32'd0);
      ticks(1);
      check("auto10.pending", {31'd0, update_pending}, 32'd1);
      frame();
      check_state("auto_step", (3 + i) % 8);
    end
    // Press accepted on the tick where the idle period would expire: one step only.
    auto_en = 1'b0;
    set_btn(1'b1, 1'b0);
    ticks(Db - 10);
    auto_en = 1'b1;
    ticks(9);
    ticks(1);
    frame();
    check_state("auto_press_wins", 4);
    ticks(9);
    check("auto_restart9.pending", {31'd0, update_pending}, 32'd0);
    ticks(1);
    check("auto_restart10.pending", {31'd0, update_pending}, 32'd1);
    auto_en = 1'b0;
    frame();
    check_state("auto_after_press", 5);
    set_btn(1'b0, 1'b0);
    ticks(Db);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
